// File: rtl/dllp_ack_scheduler_pkg.sv
// rtl/dllp_ack_scheduler_pkg.sv - DLLP payload constants and payload builder shared by the ack scheduler files
package dllp_ack_scheduler_pkg;

  localparam int         DLLP_PAYLOAD_W = 16;
  localparam logic [7:0] DLLP_TYPE_ACK  = 8'h01;
  localparam logic [7:0] DLLP_TYPE_NACK = 8'h02;

  function automatic logic [DLLP_PAYLOAD_W-1:0] dllp_payload(input logic is_nack, input logic [7:0] id);
    return {(is_nack ? DLLP_TYPE_NACK : DLLP_TYPE_ACK), id};
  endfunction

endpackage

// File: rtl/dllp_ack_coalescer.sv
// rtl/dllp_ack_coalescer.sv - pending ack/nack register with saturating ack count and duplicate-nack suppression
module dllp_ack_coalescer #(
  parameter int TLP_ID_WIDTH  = 2,
  parameter int ACK_THRESHOLD = 4,
  parameter int CNT_W         = $clog2(ACK_THRESHOLD + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [TLP_ID_WIDTH:0]   i_id_result,
  input  logic                    i_id_result_wr,
  input  logic                    i_take,
  output logic                    o_pend_vld,
  output logic                    o_pend_nack,
  output logic [TLP_ID_WIDTH-1:0] o_pend_id,
  output logic [CNT_W-1:0]        o_ack_cnt
);

  logic                    pend_vld_q, pend_vld_d;
  logic                    pend_nack_q, pend_nack_d;
  logic [TLP_ID_WIDTH-1:0] pend_id_q, pend_id_d;
  logic [CNT_W-1:0]        ack_cnt_q, ack_cnt_d;
  logic [TLP_ID_WIDTH-1:0] last_nack_id_q, last_nack_id_d;
  logic                    last_nack_vld_q, last_nack_vld_d;

  logic                    res_ack;
  logic [TLP_ID_WIDTH-1:0] res_id;

  assign res_ack = i_id_result[TLP_ID_WIDTH];
  assign res_id  = i_id_result[TLP_ID_WIDTH-1:0];

  always_comb begin
    pend_vld_d      = pend_vld_q;
    pend_nack_d     = pend_nack_q;
    pend_id_d       = pend_id_q;
    ack_cnt_d       = ack_cnt_q;
    last_nack_id_d  = last_nack_id_q;
    last_nack_vld_d = last_nack_vld_q;

    // The take clears first so a result arriving on the same edge survives into pend.
    if (i_take) begin
      pend_vld_d  = 1'b0;
      pend_nack_d = 1'b0;
      ack_cnt_d   = '0;
    end

    if (i_id_result_wr) begin
      if (res_ack) begin
        pend_vld_d      = 1'b1;
        pend_nack_d     = 1'b0;
        pend_id_d       = res_id;
        last_nack_vld_d = 1'b0;
        if (ack_cnt_d != CNT_W'(ACK_THRESHOLD)) begin
          ack_cnt_d = ack_cnt_d + CNT_W'(1);
        end
      end else if (!(last_nack_vld_q && (res_id == last_nack_id_q))) begin
        pend_vld_d      = 1'b1;
        pend_nack_d     = 1'b1;
        pend_id_d       = res_id;
        ack_cnt_d       = '0;
        last_nack_id_d  = res_id;
        last_nack_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend_vld_q      <= 1'b0;
      pend_nack_q     <= 1'b0;
      pend_id_q       <= '0;
      ack_cnt_q       <= '0;
      last_nack_id_q  <= '0;
      last_nack_vld_q <= 1'b0;
    end else begin
      pend_vld_q      <= pend_vld_d;
      pend_nack_q     <= pend_nack_d;
      pend_id_q       <= pend_id_d;
      ack_cnt_q       <= ack_cnt_d;
      last_nack_id_q  <= last_nack_id_d;
      last_nack_vld_q <= last_nack_vld_d;
    end
  end

  assign o_pend_vld  = pend_vld_q;
  assign o_pend_nack = pend_nack_q;
  assign o_pend_id   = pend_id_q;
  assign o_ack_cnt   = ack_cnt_q;

endmodule

// File: rtl/dllp_ack_scheduler.sv
// rtl/dllp_ack_scheduler.sv - ack/nack DLLP scheduler: coalescing FSM, timeout timer and req/gnt handshake
// Optional keepalive re-send of the last ack is built when DLLP_ACK_KEEPALIVE_EN is defined.
module dllp_ack_scheduler #(
  parameter int TLP_ID_WIDTH  = 2,
  parameter int ACK_THRESHOLD = 4,
  parameter int ACK_TIMEOUT   = 32,
  parameter int KEEPALIVE_CYC = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [TLP_ID_WIDTH:0] i_id_result,
  input  logic                  i_id_result_wr,
  output logic                  o_dllp_req,
  input  logic                  i_dllp_gnt,
  output logic [15:0]           o_dllp_data,
  output logic                  o_nack_pend
);
  import dllp_ack_scheduler_pkg::*;

  localparam int CNT_W = $clog2(ACK_THRESHOLD + 1);
  localparam int TMR_W = $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_COLLECT = 3'b010,
    S_REQUEST = 3'b100
  } state_t;

  state_t                      state_q, state_d;
  logic [TMR_W-1:0]            tmr_q, tmr_d;
  logic [DLLP_PAYLOAD_W-1:0]   data_q, data_d;

  logic                    take;
  logic                    go_req;
  logic                    pend_vld;
  logic                    pend_nack;
  logic                    pend_ack;
  logic [TLP_ID_WIDTH-1:0] pend_id;
  logic [CNT_W-1:0]        ack_cnt;
  logic                    cnt_full;

`ifdef DLLP_ACK_KEEPALIVE_EN
  localparam int KA_W = $clog2(KEEPALIVE_CYC);
  logic [KA_W-1:0]         idle_cnt_q, idle_cnt_d;
  logic                    ack_sent_q, ack_sent_d;
  logic [TLP_ID_WIDTH-1:0] last_ack_id_q, last_ack_id_d;
`endif

  dllp_ack_coalescer #(
    .TLP_ID_WIDTH  (TLP_ID_WIDTH),
    .ACK_THRESHOLD (ACK_THRESHOLD),
    .CNT_W         (CNT_W)
  ) u_coalescer (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_id_result    (i_id_result),
    .i_id_result_wr (i_id_result_wr),
    .i_take         (take),
    .o_pend_vld     (pend_vld),
    .o_pend_nack    (pend_nack),
    .o_pend_id      (pend_id),
    .o_ack_cnt      (ack_cnt)
  );

  assign pend_ack = pend_vld & ~pend_nack;
  assign cnt_full = (ack_cnt == CNT_W'(ACK_THRESHOLD));

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    go_req  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_vld && (pend_nack || cnt_full)) go_req = 1'b1;
        else if (pend_vld)                       state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (pend_nack || cnt_full || (tmr_q == TMR_W'(ACK_TIMEOUT - 1))) go_req = 1'b1;
      end
      S_REQUEST: begin
        // The payload register stays frozen until the framer grants it.
        if (i_dllp_gnt) begin
          if (pend_vld && pend_nack) go_req  = 1'b1;
          else if (pend_vld)         state_d = S_COLLECT;
          else                       state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    take = go_req;
    if (go_req) begin
      state_d = S_REQUEST;
      data_d  = dllp_payload(pend_nack, 8'(pend_id));
    end

    // Timer measures age of the oldest coalesced ack; it saturates instead of wrapping.
    if (go_req || !pend_ack)                      tmr_d = '0;
    else if (tmr_q != TMR_W'(ACK_TIMEOUT - 1))    tmr_d = tmr_q + TMR_W'(1);

`ifdef DLLP_ACK_KEEPALIVE_EN
    idle_cnt_d    = '0;
    ack_sent_d    = ack_sent_q;
    last_ack_id_d = last_ack_id_q;
    if ((state_q == S_REQUEST) && i_dllp_gnt && (data_q[15:8] == DLLP_TYPE_ACK)) begin
      ack_sent_d    = 1'b1;
      last_ack_id_d = data_q[TLP_ID_WIDTH-1:0];
    end
    if ((state_q == S_IDLE) && !pend_vld && !i_id_result_wr) begin
      if (idle_cnt_q == KA_W'(KEEPALIVE_CYC - 1)) begin
        if (ack_sent_q) begin
          state_d = S_REQUEST;
          data_d  = dllp_payload(1'b0, 8'(last_ack_id_q));
        end
      end else begin
        idle_cnt_d = idle_cnt_q + KA_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      data_q  <= '0;
`ifdef DLLP_ACK_KEEPALIVE_EN
      idle_cnt_q    <= '0;
      ack_sent_q    <= 1'b0;
      last_ack_id_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
`ifdef DLLP_ACK_KEEPALIVE_EN
      idle_cnt_q    <= idle_cnt_d;
      ack_sent_q    <= ack_sent_d;
      last_ack_id_q <= last_ack_id_d;
`endif
    end
  end

  assign o_dllp_req  = (state_q == S_REQUEST);
  assign o_dllp_data = data_q;
  assign o_nack_pend = pend_nack | (o_dllp_req & (data_q[15:8] == DLLP_TYPE_NACK));

endmodule

// File: tb/tb_dllp_ack_scheduler.sv
// tb/tb_dllp_ack_scheduler.sv - directed scoreboard bench for dllp_ack_scheduler
module tb_dllp_ack_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [2:0]  i_id_result;
  logic        i_id_result_wr;
  logic        o_dllp_req;
  logic        i_dllp_gnt;
  logic [15:0] o_dllp_data;
  logic        o_nack_pend;

  int n_tests = 0;
  int n_fail  = 0;
  int xfer_cnt = 0;
  logic [15:0] sb[$];

  dllp_ack_scheduler #(
    .TLP_ID_WIDTH  (2),
    .ACK_THRESHOLD (4),
    .ACK_TIMEOUT   (32),
    .KEEPALIVE_CYC (256)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_id_result    (i_id_result),
    .i_id_result_wr (i_id_result_wr),
    .o_dllp_req     (o_dllp_req),
    .i_dllp_gnt     (i_dllp_gnt),
    .o_dllp_data    (o_dllp_data),
    .o_nack_pend    (o_nack_pend)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic ack, input logic [1:0] id);
    i_id_result    = {ack, id};
    i_id_result_wr = 1'b1;
    tick();
    i_id_result_wr = 1'b0;
  endtask

  // Every granted payload is popped from the scoreboard in order.
  always @(negedge i_clk) begin
    if (i_rst_n && o_dllp_req && i_dllp_gnt) begin
      xfer_cnt++;
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL xfer_unexpected observed=%0h expected=none", o_dllp_data);
      end
      if (sb.size() != 0) check("xfer_data", 32'(o_dllp_data), 32'(sb.pop_front()));
    end
  end

  initial begin
    int x0;
    i_rst_n        = 1'b0;
    i_id_result    = '0;
    i_id_result_wr = 1'b0;
    i_dllp_gnt     = 1'b0;
    repeat (3) tick();
    check("rst_req",  32'(o_dllp_req),  32'd0);
    check("rst_data", 32'(o_dllp_data), 32'd0);
    check("rst_nack", 32'(o_nack_pend), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // 1: lone ack, grant held high
    i_dllp_gnt = 1'b1;
    x0 = xfer_cnt;
    sb.push_back(16'h0101);
    send(1'b1, 2'd1);
    repeat (31) tick();
    check("s1_req_early", 32'(o_dllp_req), 32'd0);
    tick();
    check("s1_req",  32'(o_dllp_req),  32'd1);
    check("s1_data", 32'(o_dllp_data), 32'h0101);
    repeat (40) tick();
    check("s1_xfers", 32'(xfer_cnt - x0), 32'd1);

    // 2: four acks coalesce into one
    x0 = xfer_cnt;
    sb.push_back(16'h0103);
    send(1'b1, 2'd0);
    send(1'b1, 2'd1);
    send(1'b1, 2'd2);
    send(1'b1, 2'd3);
    check("s2_req_early", 32'(o_dllp_req), 32'd0);
    tick();
    check("s2_req",  32'(o_dllp_req),  32'd1);
    check("s2_data", 32'(o_dllp_data), 32'h0103);
    repeat (40) tick();
    check("s2_xfers", 32'(xfer_cnt - x0), 32'd1);

    // 3: nack overwrites pending ack
    i_dllp_gnt = 1'b0;
    sb.push_back(16'h0203);
    send(1'b1, 2'd2);
    send(1'b0, 2'd3);
    check("s3_req_early", 32'(o_dllp_req), 32'd0);
    tick();
    check("s3_req",   32'(o_dllp_req),  32'd1);
    check("s3_data",  32'(o_dllp_data), 32'h0203);
    check("s3_npend", 32'(o_nack_pend), 32'd1);
    i_dllp_gnt = 1'b1;
    tick();
    i_dllp_gnt = 1'b0;
    check("s3_req_drop", 32'(o_dllp_req),  32'd0);
    check("s3_npend_clr", 32'(o_nack_pend), 32'd0);

    // 4: duplicate nacks suppressed until an ack intervenes
    x0 = xfer_cnt;
    sb.push_back(16'h0201);
    send(1'b0, 2'd1);
    send(1'b0, 2'd1);
    send(1'b0, 2'd1);
    repeat (10) tick();
    check("s4_req",   32'(o_dllp_req),  32'd1);
    check("s4_npend", 32'(o_nack_pend), 32'd1);
    i_dllp_gnt = 1'b1;
    tick();
    i_dllp_gnt = 1'b0;
    repeat (5) tick();
    check("s4_req_idle", 32'(o_dllp_req), 32'd0);
    check("s4_xfers1", 32'(xfer_cnt - x0), 32'd1);
    sb.push_back(16'h0201);
    send(1'b1, 2'd1);
    send(1'b0, 2'd1);
    tick();
    check("s4_data2", 32'(o_dllp_data), 32'h0201);
    i_dllp_gnt = 1'b1;
    repeat (5) tick();
    i_dllp_gnt = 1'b0;
    check("s4_xfers2", 32'(xfer_cnt - x0), 32'd2);

    // 5: result strobe coincident with grant
    sb.push_back(16'h0101);
    send(1'b1, 2'd1);
    repeat (32) tick();
    check("s5_req",  32'(o_dllp_req),  32'd1);
    check("s5_data", 32'(o_dllp_data), 32'h0101);
    sb.push_back(16'h0102);
    i_id_result    = 3'b110;
    i_id_result_wr = 1'b1;
    i_dllp_gnt     = 1'b1;
    tick();
    i_id_result_wr = 1'b0;
    i_dllp_gnt     = 1'b0;
    check("s5_req_drop", 32'(o_dllp_req), 32'd0);
    repeat (31) tick();
    check("s5_req_early", 32'(o_dllp_req), 32'd0);
    tick();
    check("s5_req2",  32'(o_dllp_req),  32'd1);
    check("s5_data2", 32'(o_dllp_data), 32'h0102);
    i_dllp_gnt = 1'b1;
    tick();
    i_dllp_gnt = 1'b0;

    // 6: reset drops an outstanding request
    send(1'b0, 2'd2);
    tick();
    check("s6_req", 32'(o_dllp_req), 32'd1);
    i_rst_n = 1'b0;
    tick();
    check("s6_rst_req",   32'(o_dllp_req),  32'd0);
    check("s6_rst_data",  32'(o_dllp_data), 32'd0);
    check("s6_rst_npend", 32'(o_nack_pend), 32'd0);
    i_rst_n = 1'b1;
    tick();
    sb.push_back(16'h0202);
    send(1'b0, 2'd2);
    tick();
    check("s6_nack_after_rst", 32'(o_dllp_data), 32'h0202);
    i_dllp_gnt = 1'b1;
    tick();
    i_dllp_gnt = 1'b0;

`ifdef DLLP_ACK_KEEPALIVE_EN
    i_dllp_gnt = 1'b1;
    sb.push_back(16'h0101);
    send(1'b1, 2'd1);
    repeat (40) tick();
    i_dllp_gnt = 1'b0;
    sb.push_back(16'h0101);
    begin
      int k;
      k = 0;
      while (!o_dllp_req && k < 400) begin
        tick();
        k++;
      end
      check("ka_req_seen", 32'(o_dllp_req), 32'd1);
      check("ka_data", 32'(o_dllp_data), 32'h0101);
    end
    i_dllp_gnt = 1'b1;
    tick();
    i_dllp_gnt = 1'b0;
`endif

    repeat (5) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
